// File: rtl/pipe_adder_pkg.sv
// Shared definitions for the two-stage pipelined adder/subtractor.
package pipe_adder_pkg;

  localparam int unsigned OP_W = 2;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_SAT = 2'b10,
    OP_RSV = 2'b11
  } op_e;

endpackage

// File: rtl/pipe_adder_stage_ctrl.sv
// One pipeline stage's valid bit and advance logic.
module pipe_stage_ctrl (
  input  logic clk,
  input  logic rst,
  input  logic up_valid,
  input  logic down_adv,
  output logic adv_c,
  output logic valid
);

  logic valid_q;
  logic valid_d;

  // A stage advances when empty or when the stage below it moves.
  always_comb begin
    adv_c   = !valid_q || down_adv;
    valid_d = valid_q;
    if (adv_c) begin
      valid_d = up_valid;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
    end
  end

  assign valid = valid_q;

endmodule

// File: rtl/pipe_adder.sv
// Two-stage pipelined add / subtract / saturating-add with valid/ready flow control.
module pipe_adder
  import pipe_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned LOW_W = WIDTH / 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   sum,
  output logic             ovf
);

  localparam int unsigned HI_W = WIDTH - LOW_W;

  typedef struct packed {
    logic [LOW_W-1:0] lo_sum;
    logic             lo_c;
    logic [HI_W-1:0]  a_hi;
    logic [HI_W-1:0]  bb_hi;
    op_e              op;
  } s1_t;

  logic s1_valid;
  logic s2_valid;
  logic s1_adv;
  logic s2_adv;

  pipe_stage_ctrl u_s1_ctrl (
    .clk      (clk),
    .rst      (rst),
    .up_valid (in_valid),
    .down_adv (s2_adv),
    .adv_c    (s1_adv),
    .valid    (s1_valid)
  );

  pipe_stage_ctrl u_s2_ctrl (
    .clk      (clk),
    .rst      (rst),
    .up_valid (s1_valid),
    .down_adv (out_ready),
    .adv_c    (s2_adv),
    .valid    (s2_valid)
  );

  assign in_ready  = s1_adv;
  assign out_valid = s2_valid;

  s1_t              s1_q;
  s1_t              s1_d;
  logic [WIDTH-1:0] bb;
  logic             cin;
  logic [LOW_W:0]   lo;

  // Stage 1: low slice, with subtract folded in as A + ~B + 1.
  always_comb begin
    s1_d = s1_q;
    cin  = (op == OP_SUB);
    bb   = cin ? ~b : b;
    lo   = {1'b0, a[LOW_W-1:0]} + {1'b0, bb[LOW_W-1:0]} + (LOW_W+1)'(cin);
    if (in_valid && in_ready) begin
      s1_d.lo_sum = lo[LOW_W-1:0];
      s1_d.lo_c   = lo[LOW_W];
      s1_d.a_hi   = a[WIDTH-1:LOW_W];
      s1_d.bb_hi  = bb[WIDTH-1:LOW_W];
      s1_d.op     = op_e'(op);
    end
  end

  logic [WIDTH:0]   sum_q;
  logic [WIDTH:0]   sum_d;
  logic             ovf_q;
  logic             ovf_d;
  logic [HI_W:0]    hi;
  logic [WIDTH-1:0] raw;
  logic             c;

  // Stage 2: high slice plus mode-specific result formatting.
  always_comb begin
    sum_d = sum_q;
    ovf_d = ovf_q;
    hi    = {1'b0, s1_q.a_hi} + {1'b0, s1_q.bb_hi} + (HI_W+1)'(s1_q.lo_c);
    raw   = {hi[HI_W-1:0], s1_q.lo_sum};
    c     = hi[HI_W];
    if (s2_adv && s1_valid) begin
      case (s1_q.op)
        OP_SUB: begin
          sum_d = {~c, raw};
          ovf_d = ~c;
        end
        OP_SAT: begin
          sum_d = c ? {1'b0, {WIDTH{1'b1}}} : {1'b0, raw};
          ovf_d = c;
        end
        default: begin
          sum_d = {c, raw};
          ovf_d = c;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q  <= '0;
      sum_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      s1_q  <= s1_d;
      sum_q <= sum_d;
      ovf_q <= ovf_d;
    end
  end

  assign sum = sum_q;
  assign ovf = ovf_q;

endmodule

// File: tb/tb_pipe_adder.sv
// Directed, table-driven bench for pipe_adder at WIDTH=4.
module tb_pipe_adder;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [1:0]   op;
  logic         out_valid;
  logic         out_ready;
  logic [W:0]   sum;
  logic         ovf;

  pipe_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [1:0]   op;
    logic [W:0]   s;
    logic         o;
  } vec_t;

  typedef struct {
    logic [W:0] s;
    logic       o;
    int         c;
    bit         lat;
  } exp_t;

  exp_t q[$];
  vec_t cur;
  bit   cur_lat;
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Scoreboard: record accepted inputs, compare each delivered result in order.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (in_valid && in_ready) q.push_back('{cur.s, cur.o, cyc, cur_lat});
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("unexpected_out", 1, 0);
        end else begin
          e = q.pop_front();
          check("sum", longint'(sum), longint'(e.s));
          check("ovf", longint'(ovf), longint'(e.o));
          if (e.lat) check("latency", cyc - e.c, 2);
        end
      end
    end
  end

  task automatic drive(input vec_t v, input bit lat);
    int n;
    cur      = v;
    cur_lat  = lat;
    a        = v.a;
    b        = v.b;
    op       = v.op;
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("in_ready_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("drain_empty", q.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  vec_t tbl[$];
  vec_t bp[4];
  vec_t v;

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    op        = 2'b00;
    out_ready = 1'b1;
    cur       = '{default: '0};
    cur_lat   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", sum, 0);
    check("rst_ovf", ovf, 0);
    check("rst_in_ready", in_ready, 1);
    rst = 1'b0;

    for (int i = 0; i <= 6; i++) begin
      v = '{W'(i), W'(i), 2'b00, (W+1)'(2 * i), 1'b0};
      tbl.push_back(v);
    end
    tbl.push_back('{4'd7,  4'd9,  2'b00, 5'd16, 1'b1});
    tbl.push_back('{4'd15, 4'd15, 2'b00, 5'd30, 1'b1});
    tbl.push_back('{4'd3,  4'd5,  2'b01, 5'd30, 1'b1});
    tbl.push_back('{4'd9,  4'd4,  2'b01, 5'd5,  1'b0});
    tbl.push_back('{4'd6,  4'd6,  2'b01, 5'd0,  1'b0});
    tbl.push_back('{4'd12, 4'd9,  2'b10, 5'd15, 1'b1});
    tbl.push_back('{4'd5,  4'd6,  2'b10, 5'd11, 1'b0});
    tbl.push_back('{4'd7,  4'd9,  2'b11, 5'd16, 1'b1});
    tbl.push_back('{4'd0,  4'd1,  2'b01, 5'd31, 1'b1});

    @(posedge clk);
    #1;
    foreach (tbl[i]) drive(tbl[i], 1'b1);
    drain();

    // Backpressure: consumer stalls five cycles while four pairs are offered.
    bp[0] = '{4'd1, 4'd1, 2'b00, 5'd2, 1'b0};
    bp[1] = '{4'd2, 4'd2, 2'b00, 5'd4, 1'b0};
    bp[2] = '{4'd3, 4'd3, 2'b00, 5'd6, 1'b0};
    bp[3] = '{4'd4, 4'd4, 2'b00, 5'd8, 1'b0};
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++) drive(bp[i], 1'b0);
      end
      begin
        for (int k = 1; k <= 5; k++) begin
          @(negedge clk);
          if (k >= 3) begin
            check("bp_in_ready", in_ready, 0);
            check("bp_out_valid", out_valid, 1);
            check("bp_sum_hold", sum, 2);
          end
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Asynchronous reset with two results in flight.
    @(posedge clk);
    #1;
    drive('{4'd7, 4'd9, 2'b00, 5'd16, 1'b1}, 1'b0);
    drive('{4'd15, 4'd15, 2'b00, 5'd30, 1'b1}, 1'b0);
    check("pre_rst_out_valid", out_valid, 1);
    #1;
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_sum", sum, 0);
    check("mid_rst_ovf", ovf, 0);
    q.delete();
    #4;
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("post_rst_in_ready", in_ready, 1);
      check("post_rst_no_stale", out_valid, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
